// File: rtl/adder_tree_if.sv
// Beat/result bundle for adder_tree_pipe: lane data in, signed sum out.
// Parameters must agree with the instance using it (OUT_W = IN_W + log2(NUM_IN) + log2(ACC_LEN)).
interface adder_tree_if #(
    parameter int NUM_IN = 8,
    parameter int IN_W   = 12,
    parameter int OUT_W  = 17
);
    logic                     in_valid;
    logic [NUM_IN*IN_W-1:0]   in_data;
    logic                     acc_mode;
    logic                     acc_clr;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_sum;

    modport master (
        output in_valid, in_data, acc_mode, acc_clr,
        input  out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_data, acc_mode, acc_clr,
        output out_valid, out_sum
    );
endinterface

// File: rtl/adder_tree_pipe.sv
// Fully pipelined signed adder tree over NUM_IN lanes with an optional
// ACC_LEN-beat accumulator at the output; one beat in and one result out per clock.
module adder_tree_pipe #(
    parameter int NUM_IN  = 8,
    parameter int IN_W    = 12,
    parameter int SPLIT   = 1,
    parameter int ACC_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_tree_if.slave  bus
);
    localparam int LOG2N = $clog2(NUM_IN);
    localparam int ACC_G = $clog2(ACC_LEN);
    localparam int SUM_W = IN_W + LOG2N;
    localparam int OUT_W = SUM_W + ACC_G;
    localparam int T     = LOG2N * (SPLIT + 1);

    // Input capture stage; the tree proper starts from these registers.
    logic [NUM_IN*IN_W-1:0] in_data_reg;
    logic                   in_valid_reg;
    logic                   in_mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_data_reg  <= '0;
            in_valid_reg <= 1'b0;
            in_mode_reg  <= 1'b0;
        end else begin
            in_data_reg  <= bus.in_data;
            in_valid_reg <= bus.in_valid;
            in_mode_reg  <= bus.acc_mode;
        end
    end

    for (genvar gi = 0; gi < LOG2N; gi++) begin : lvl
        localparam int WI = IN_W + gi;
        localparam int W  = WI + 1;
        localparam int NP = NUM_IN >> (gi + 1);

        logic [2*NP*WI-1:0] src;
        logic [NP*W-1:0]    dout;

        if (gi == 0) begin : g_src_first
            assign src = in_data_reg;
        end else begin : g_src_prev
            assign src = lvl[gi-1].dout;
        end

        if (SPLIT == 0) begin : g_whole
            logic [NP*W-1:0] sum_c;

            always_comb begin
                sum_c = '0;
                for (int k = 0; k < NP; k++) begin
                    sum_c[k*W +: W] = {src[(2*k+1)*WI-1], src[2*k*WI +: WI]}
                                    + {src[(2*k+2)*WI-1], src[(2*k+1)*WI +: WI]};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout <= '0;
                else        dout <= sum_c;
            end
        end else begin : g_split
            localparam int L = (W + 1) / 2;
            localparam int H = W - L;

            logic [NP*L-1:0] lo_c, lo_reg;
            logic [NP-1:0]   cy_c, cy_reg;
            logic [NP*H-1:0] ah_c, bh_c, ah_reg, bh_reg, hi_c;
            logic [NP*W-1:0] res_c;

            // Low half adds now; the sign-extended high halves wait one stage for the carry.
            always_comb begin
                lo_c = '0;
                cy_c = '0;
                ah_c = '0;
                bh_c = '0;
                for (int k = 0; k < NP; k++) begin
                    {cy_c[k], lo_c[k*L +: L]} = {1'b0, src[2*k*WI +: L]}
                                              + {1'b0, src[(2*k+1)*WI +: L]};
                    ah_c[k*H +: H] = {src[(2*k+1)*WI-1], src[2*k*WI+L +: WI-L]};
                    bh_c[k*H +: H] = {src[(2*k+2)*WI-1], src[(2*k+1)*WI+L +: WI-L]};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_reg <= '0;
                    cy_reg <= '0;
                    ah_reg <= '0;
                    bh_reg <= '0;
                end else begin
                    lo_reg <= lo_c;
                    cy_reg <= cy_c;
                    ah_reg <= ah_c;
                    bh_reg <= bh_c;
                end
            end

            always_comb begin
                hi_c  = '0;
                res_c = '0;
                for (int k = 0; k < NP; k++) begin
                    hi_c[k*H +: H]  = ah_reg[k*H +: H] + bh_reg[k*H +: H] + H'(cy_reg[k]);
                    res_c[k*W +: W] = {hi_c[k*H +: H], lo_reg[k*L +: L]};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout <= '0;
                else        dout <= res_c;
            end
        end
    end

    // Valid and mode ride alongside the data through every tree stage.
    logic [T-1:0] vld_sr;
    logic [T-1:0] mode_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            mode_sr <= '0;
        end else begin
            vld_sr  <= (vld_sr << 1) | T'(in_valid_reg);
            mode_sr <= (mode_sr << 1) | T'(in_mode_reg);
        end
    end

    logic             tree_valid;
    logic             tree_mode;
    logic [SUM_W-1:0] tree_sum;
    logic [OUT_W-1:0] tree_ext;

    assign tree_valid = vld_sr[T-1];
    assign tree_mode  = mode_sr[T-1];
    assign tree_sum   = lvl[LOG2N-1].dout;
    assign tree_ext   = {{ACC_G{tree_sum[SUM_W-1]}}, tree_sum};

    logic             out_valid_reg, out_valid_next;
    logic [OUT_W-1:0] out_sum_reg,   out_sum_next;
    logic [OUT_W-1:0] acc_reg,       acc_next;
    logic [ACC_G-1:0] cnt_reg,       cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_sum_reg   <= out_sum_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
        end
    end

    // A clear that meets a mode-1 result restarts the total from that result.
    always_comb begin
        out_valid_next = 1'b0;
        out_sum_next   = out_sum_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        if (tree_valid) begin
            if (!tree_mode) begin
                out_sum_next   = tree_ext;
                out_valid_next = 1'b1;
                cnt_next       = '0;
            end else if (bus.acc_clr || cnt_reg == '0) begin
                acc_next = tree_ext;
                cnt_next = ACC_G'(1);
            end else if (cnt_reg == ACC_G'(ACC_LEN - 1)) begin
                out_sum_next   = acc_reg + tree_ext;
                out_valid_next = 1'b1;
                cnt_next       = '0;
            end else begin
                acc_next = acc_reg + tree_ext;
                cnt_next = cnt_reg + ACC_G'(1);
            end
        end else if (bus.acc_clr) begin
            cnt_next = '0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_sum   = out_sum_reg;
endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: drives a SPLIT=1 and a SPLIT=0 instance
// with the same beats and checks both against a cycle-level reference model.
module tb_adder_tree_pipe;
    localparam int NUM_IN = 8;
    localparam int IN_W   = 12;
    localparam int OUT_W  = 17;
    localparam int HN     = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic acc_mode = 1'b0;
    logic acc_clr = 1'b0;
    logic [NUM_IN*IN_W-1:0] in_data = '0;

    always #5 clk = ~clk;

    adder_tree_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus0 ();
    adder_tree_if #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_data  = in_data;
    assign bus0.acc_mode = acc_mode;
    assign bus0.acc_clr  = acc_clr;
    assign bus1.in_valid = in_valid;
    assign bus1.in_data  = in_data;
    assign bus1.acc_mode = acc_mode;
    assign bus1.acc_clr  = acc_clr;

    adder_tree_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .SPLIT(1), .ACC_LEN(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    adder_tree_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .SPLIT(0), .ACC_LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat [2] = '{7, 4};

    // Reference model: beat history by edge, plus the output-side totals.
    bit hv [HN];
    bit hm [HN];
    int hs [HN];
    int m_acc [2];
    int m_cnt [2];
    int m_sum [2];
    bit m_v [2];
    int q_v0 [$];
    int q_e0 [$];
    int q_v1 [$];
    int q_e1 [$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int e, s, ts, src, a0, a1;
        e = cyc;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < HN; i++) hv[i] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_acc[d] = 0; m_cnt[d] = 0; m_sum[d] = 0; m_v[d] = 1'b0;
            end
        end else begin
            s = 0;
            for (int k = 0; k < NUM_IN; k++) s += int'($signed(in_data[k*IN_W +: IN_W]));
            hv[e % HN] = in_valid;
            hm[e % HN] = acc_mode;
            hs[e % HN] = s;
            for (int d = 0; d < 2; d++) begin
                m_v[d] = 1'b0;
                src = (e - lat[d]) % HN;
                if (e >= lat[d] && hv[src]) begin
                    ts = hs[src];
                    if (!hm[src]) begin
                        m_sum[d] = ts; m_v[d] = 1'b1; m_cnt[d] = 0;
                    end else if (acc_clr || m_cnt[d] == 0) begin
                        m_acc[d] = ts; m_cnt[d] = 1;
                    end else if (m_cnt[d] == 3) begin
                        m_sum[d] = m_acc[d] + ts; m_v[d] = 1'b1; m_cnt[d] = 0;
                    end else begin
                        m_acc[d] += ts; m_cnt[d]++;
                    end
                end else if (acc_clr) begin
                    m_cnt[d] = 0;
                end
            end
        end
        #1;
        a0 = $signed(bus0.out_sum);
        a1 = $signed(bus1.out_sum);
        chk("split1_out_valid", int'(bus0.out_valid), int'(m_v[0]));
        chk("split1_out_sum", a0, m_sum[0]);
        chk("split0_out_valid", int'(bus1.out_valid), int'(m_v[1]));
        chk("split0_out_sum", a1, m_sum[1]);
        if (bus0.out_valid) begin q_v0.push_back(a0); q_e0.push_back(e); end
        if (bus1.out_valid) begin q_v1.push_back(a1); q_e1.push_back(e); end
    end

    int last_edge;

    task automatic beat(input bit m, input int base, input int step);
        @(negedge clk);
        in_valid = 1'b1;
        acc_mode = m;
        acc_clr  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) in_data[k*IN_W +: IN_W] = IN_W'(base + step*k);
        last_edge = cyc;
        $display("beat edge=%0d mode=%0d lanes=%0d+%0d*k", cyc, m, base, step);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            acc_mode = 1'b0;
            acc_clr  = 1'b0;
        end
    endtask

    task automatic clear_q();
        q_v0.delete(); q_e0.delete(); q_v1.delete(); q_e1.delete();
    endtask

    // Literal pin: pulse idx of instance d must carry val at the given edge.
    task automatic pulse(input string nm, input int d, input int idx, input int val, input int edge_no);
        int n, v, eg;
        n = (d == 0) ? q_v0.size() : q_v1.size();
        total++;
        if (n <= idx) begin
            bad++;
            $display("FAIL %s: only %0d pulses, want pulse #%0d = %0d", nm, n, idx, val);
        end else begin
            v  = (d == 0) ? q_v0[idx] : q_v1[idx];
            eg = (d == 0) ? q_e0[idx] : q_e1[idx];
            if (v != val || eg != edge_no) begin
                bad++;
                $display("FAIL %s: got %0d at edge %0d, want %0d at edge %0d", nm, v, eg, val, edge_no);
            end
            $display("pulse %s dut%0d value=%0d edge=%0d", nm, d, v, eg);
        end
    endtask

    initial begin
        int b1, bz, b8;
        idle(3);
        chk("reset_out_valid", int'(bus0.out_valid), 0);
        chk("reset_out_sum", int'(bus0.out_sum), 0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        clear_q();
        beat(1'b0, 2047, 0); b1 = last_edge;
        idle(10);
        chk("max_count", q_v0.size(), 1);
        pulse("max_sum", 0, 0, 16376, b1 + 7);
        pulse("max_sum_s0", 1, 0, 16376, b1 + 4);

        clear_q();
        beat(1'b0, -2048, 0); b1 = last_edge;
        idle(10);
        pulse("min_sum", 0, 0, -16384, b1 + 7);

        clear_q();
        for (int i = 1; i <= 8; i++) begin
            beat(1'b0, i, i);
            if (i == 1) b1 = last_edge;
        end
        idle(10);
        chk("stream_count", q_v0.size(), 8);
        for (int i = 0; i < 8; i++) pulse("stream", 0, i, 36*(i+1), b1 + 7 + i);

        clear_q();
        beat(1'b1, 1000, 0);
        beat(1'b1, 1000, 0);
        idle(2);
        beat(1'b1, 1000, 0);
        beat(1'b1, 1000, 0); b8 = last_edge;
        idle(10);
        chk("acc_bubble_count", q_v0.size(), 1);
        pulse("acc_bubble", 0, 0, 32000, b8 + 7);

        clear_q();
        for (int i = 0; i < 4; i++) beat(1'b1, -2048, 0);
        b8 = last_edge;
        idle(10);
        pulse("acc_min", 0, 0, -65536, b8 + 7);
        pulse("acc_min_s0", 1, 0, -65536, b8 + 4);

        clear_q();
        beat(1'b1, 7, 0);
        beat(1'b1, 7, 0);
        idle(10);
        @(negedge clk);
        acc_clr = 1'b1;
        $display("acc_clr edge=%0d", cyc);
        for (int i = 0; i < 4; i++) beat(1'b1, 5, 0);
        b8 = last_edge;
        idle(10);
        chk("clr_count", q_v0.size(), 1);
        pulse("clr_sum", 0, 0, 160, b8 + 7);

        clear_q();
        beat(1'b1, 7, 0);
        beat(1'b1, 7, 0);
        beat(1'b0, 3, 0); bz = last_edge;
        for (int i = 0; i < 4; i++) beat(1'b1, 5, 0);
        b8 = last_edge;
        idle(10);
        chk("abort_count", q_v0.size(), 2);
        pulse("abort_plain", 0, 0, 24, bz + 7);
        pulse("abort_acc", 0, 1, 160, b8 + 7);

        beat(1'b1, 9, 0);
        beat(1'b1, 9, 0);
        idle(8);
        for (int i = 0; i < 3; i++) beat(1'b1, 9, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus0.out_valid), 0);
        chk("midrst_sum", int'(bus0.out_sum), 0);
        chk("midrst_sum_s0", int'(bus1.out_sum), 0);
        @(negedge clk) rst_n = 1'b1;
        clear_q();
        idle(12);
        chk("no_stale", q_v0.size() + q_v1.size(), 0);
        beat(1'b0, 1, 0); b1 = last_edge;
        for (int i = 0; i < 4; i++) beat(1'b1, 5, 0);
        b8 = last_edge;
        idle(10);
        pulse("post_rst_plain", 0, 0, 8, b1 + 7);
        pulse("post_rst_acc", 0, 1, 160, b8 + 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
